// File: rtl/vend_pkg.sv
// vend_pkg: shared types and constants for the vending sequencer.
//   state_t     : top-level controller states (IDLE, COLLECT, VEND, CHANGE)
//   credit_t    : 4-bit shilling amount (credit or change)
//   *_V         : coin values in shillings
//   coin_value  : value of a single asserted coin pulse
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } state_t;

  typedef logic [3:0] credit_t;

  localparam credit_t SHILLING_V = 4'd1;
  localparam credit_t FLORIN_V   = 4'd2;
  localparam credit_t CROWN_V    = 4'd5;

  // Only meaningful when exactly one pulse is high.
  function automatic credit_t coin_value(input logic s, input logic f, input logic c);
    credit_t v;
    v = '0;
    if (s)      v = SHILLING_V;
    else if (f) v = FLORIN_V;
    else if (c) v = CROWN_V;
    return v;
  endfunction

endpackage

// File: rtl/vend_payout.sv
// vend_payout: hopper handshake loop that pays an amount out greedily,
// florins first, then a final shilling.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : load amount and begin paying (request raised at once)
//   amount       : shillings to pay
//   hopper_ack   : hopper ejected the requested coin
//   florin       : request one florin, held until hopper_ack
//   shilling     : request one shilling, held until hopper_ack
//   remaining    : shillings still owed
//   done         : payout active, nothing requested and nothing owed
module vend_payout
  import vend_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    start,
  input  credit_t amount,
  input  logic    hopper_ack,
  output logic    florin,
  output logic    shilling,
  output credit_t remaining,
  output logic    done
);

  credit_t r_rem;
  logic    r_active;
  logic    r_florin;
  logic    r_shilling;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem      <= '0;
      r_active   <= 1'b0;
      r_florin   <= 1'b0;
      r_shilling <= 1'b0;
    end else if (start) begin
      r_rem      <= amount;
      r_active   <= 1'b1;
      r_florin   <= (amount >= FLORIN_V);
      r_shilling <= (amount == SHILLING_V);
    end else if (r_active) begin
      if (r_florin && hopper_ack) begin
        r_florin <= 1'b0;
        r_rem    <= r_rem - FLORIN_V;
      end else if (r_shilling && hopper_ack) begin
        r_shilling <= 1'b0;
        r_rem      <= r_rem - SHILLING_V;
      end else if (!r_florin && !r_shilling) begin
        // Gap cycle after an ack: raise the next request or finish.
        if (r_rem >= FLORIN_V)        r_florin   <= 1'b1;
        else if (r_rem == SHILLING_V) r_shilling <= 1'b1;
        else                          r_active   <= 1'b0;
      end
    end
  end

  assign florin    = r_florin;
  assign shilling  = r_shilling;
  assign remaining = r_rem;
  assign done      = r_active && !r_florin && !r_shilling && (r_rem == '0);

endmodule

// File: rtl/vend_sequencer.sv
// vend_sequencer: vending machine controller. Accumulates coin credit,
// releases the product once PRICE is reached and pays change through the
// hopper handshake in vend_payout.
// Optional feature: define VEND_REFUND_EN to add the cancel port (refund of
// collected credit without dispensing).
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   coin_shilling/florin/crown : 1-cycle coin pulses (1/2/5 shillings)
//   cancel              : refund request (VEND_REFUND_EN only)
//   hopper_ack          : hopper ejected the requested coin
//   cState              : credit (IDLE/COLLECT) or change (VEND/CHANGE)
//   dispense            : product release, DISP_CYCLES cycles
//   florin, shilling    : hopper eject requests
//   coin_reject         : 1-cycle pulse, last coin not credited
//   busy                : high in VEND and CHANGE
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int PRICE       = 4,
  parameter int DISP_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       coin_shilling,
  input  logic       coin_florin,
  input  logic       coin_crown,
`ifdef VEND_REFUND_EN
  input  logic       cancel,
`endif
  input  logic       hopper_ack,
  output logic [3:0] cState,
  output logic       dispense,
  output logic       florin,
  output logic       shilling,
  output logic       coin_reject,
  output logic       busy
);

  localparam credit_t PRICE_C = credit_t'(PRICE);
  localparam credit_t DISP_C  = credit_t'(DISP_CYCLES);

  // Reset asserts asynchronously and releases on a clock edge.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= '0;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  state_t  r_state, w_state_nx;
  credit_t r_cstate, w_cstate_nx;
  credit_t r_cnt, w_cnt_nx;
  logic    r_dispense, w_disp_nx;
  logic    r_reject, w_reject_nx;
  logic    r_busy, w_busy_nx;

  logic       w_cancel;
  logic [1:0] w_ncoins;
  logic       w_any_coin;
  logic       w_start;
  logic       w_done;
  credit_t    w_remaining;

`ifdef VEND_REFUND_EN
  assign w_cancel = cancel;
`else
  assign w_cancel = 1'b0;
`endif

  assign w_ncoins   = 2'(coin_shilling) + 2'(coin_florin) + 2'(coin_crown);
  assign w_any_coin = (w_ncoins != 2'd0);

  // The payout amount is whatever cState holds: change in VEND, credit on refund.
  vend_payout u_payout (
    .clk        (clk),
    .rst_n      (w_rst_n),
    .start      (w_start),
    .amount     (r_cstate),
    .hopper_ack (hopper_ack),
    .florin     (florin),
    .shilling   (shilling),
    .remaining  (w_remaining),
    .done       (w_done)
  );

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state    <= IDLE;
      r_cstate   <= '0;
      r_cnt      <= '0;
      r_dispense <= 1'b0;
      r_reject   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_cstate   <= w_cstate_nx;
      r_cnt      <= w_cnt_nx;
      r_dispense <= w_disp_nx;
      r_reject   <= w_reject_nx;
      r_busy     <= w_busy_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_cstate_nx = r_cstate;
    w_cnt_nx    = r_cnt;
    w_disp_nx   = r_dispense;
    w_reject_nx = 1'b0;
    w_start     = 1'b0;
    case (r_state)
      IDLE, COLLECT: begin
        if ((r_state == COLLECT) && (r_cstate >= PRICE_C)) begin
          // Purchase committed: coins arriving now are not credited.
          w_state_nx  = VEND;
          w_cstate_nx = r_cstate - PRICE_C;
          w_disp_nx   = 1'b1;
          w_cnt_nx    = DISP_C;
          w_reject_nx = w_any_coin;
        end else if ((r_state == COLLECT) && w_cancel) begin
          w_state_nx  = CHANGE;
          w_start     = 1'b1;
          w_reject_nx = w_any_coin;
        end else if (w_ncoins == 2'd1) begin
          w_state_nx  = COLLECT;
          w_cstate_nx = r_cstate + coin_value(coin_shilling, coin_florin, coin_crown);
        end else if (w_any_coin) begin
          w_reject_nx = 1'b1;
        end
      end
      VEND: begin
        w_reject_nx = w_any_coin;
        if (r_cnt <= 4'd1) begin
          w_state_nx = CHANGE;
          w_disp_nx  = 1'b0;
          w_cnt_nx   = '0;
          w_start    = 1'b1;
        end else begin
          w_cnt_nx = r_cnt - 4'd1;
        end
      end
      CHANGE: begin
        w_reject_nx = w_any_coin;
        w_cstate_nx = w_remaining;
        if (w_done) begin
          w_state_nx  = IDLE;
          w_cstate_nx = '0;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  assign w_busy_nx = (w_state_nx == VEND) || (w_state_nx == CHANGE);

  assign cState      = r_cstate;
  assign dispense    = r_dispense;
  assign coin_reject = r_reject;
  assign busy        = r_busy;

endmodule

// File: tb/tb_vend_sequencer.sv
module tb_vend_sequencer;

  localparam int DISP = 3;
  localparam int NDUT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic [2:0] coins  [NDUT];
  logic       ack    [NDUT];
  logic       cancel [NDUT];
  logic [3:0] cs     [NDUT];
  logic       disp   [NDUT];
  logic       fl     [NDUT];
  logic       sh     [NDUT];
  logic       rej    [NDUT];
  logic       bsy    [NDUT];

  int checks = 0;
  int errors = 0;

  vend_sequencer #(.PRICE(4), .DISP_CYCLES(DISP)) u_p4 (
    .clk(clk), .reset_n(reset_n),
    .coin_shilling(coins[0][0]), .coin_florin(coins[0][1]), .coin_crown(coins[0][2]),
`ifdef VEND_REFUND_EN
    .cancel(cancel[0]),
`endif
    .hopper_ack(ack[0]), .cState(cs[0]), .dispense(disp[0]), .florin(fl[0]),
    .shilling(sh[0]), .coin_reject(rej[0]), .busy(bsy[0]));

  vend_sequencer #(.PRICE(1), .DISP_CYCLES(DISP)) u_p1 (
    .clk(clk), .reset_n(reset_n),
    .coin_shilling(coins[1][0]), .coin_florin(coins[1][1]), .coin_crown(coins[1][2]),
`ifdef VEND_REFUND_EN
    .cancel(cancel[1]),
`endif
    .hopper_ack(ack[1]), .cState(cs[1]), .dispense(disp[1]), .florin(fl[1]),
    .shilling(sh[1]), .coin_reject(rej[1]), .busy(bsy[1]));

  vend_sequencer #(.PRICE(10), .DISP_CYCLES(DISP)) u_p10 (
    .clk(clk), .reset_n(reset_n),
    .coin_shilling(coins[2][0]), .coin_florin(coins[2][1]), .coin_crown(coins[2][2]),
`ifdef VEND_REFUND_EN
    .cancel(cancel[2]),
`endif
    .hopper_ack(ack[2]), .cState(cs[2]), .dispense(disp[2]), .florin(fl[2]),
    .shilling(sh[2]), .coin_reject(rej[2]), .busy(bsy[2]));

  function automatic int price_of(input int i);
    case (i)
      0:       return 4;
      1:       return 1;
      default: return 10;
    endcase
  endfunction

  // {cState, dispense, florin, shilling, coin_reject, busy}
  function automatic logic [8:0] outv(input int i);
    return {cs[i], disp[i], fl[i], sh[i], rej[i], bsy[i]};
  endfunction

  function automatic logic [8:0] ev(input int c, input logic d, input logic f,
                                    input logic s, input logic r, input logic b);
    return {4'(c), d, f, s, r, b};
  endfunction

  task automatic check(input string name, input int idx, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %b required %b (cState,disp,florin,shilling,reject,busy)",
               name, idx, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, got, exp);
    end
  endtask

  // Apply one cycle of inputs to DUT i; outputs are sampled 1ns after the edge.
  task automatic tick(input int i, input logic [2:0] c, input logic a, input logic k);
    coins[i]  = c;
    ack[i]    = a;
    cancel[i] = k;
    @(posedge clk);
    #1;
    coins[i]  = '0;
    ack[i]    = 1'b0;
    cancel[i] = 1'b0;
  endtask

  task automatic do_reset();
    for (int i = 0; i < NDUT; i++) begin
      coins[i] = '0; ack[i] = 1'b0; cancel[i] = 1'b0;
    end
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural reference model ----------------
  // Tracks credit, remaining dispense cycles and the list of coins still
  // to be paid out; outputs are what should be visible after each edge.
  int m_credit, m_disp_left, m_shown;
  bit m_in_change, m_req_on, m_rej;
  int m_pay[$];

  task automatic model_reset();
    m_credit = 0; m_disp_left = 0; m_shown = 0;
    m_in_change = 0; m_req_on = 0; m_rej = 0;
    m_pay.delete();
  endtask

  task automatic fill_pay(input int amt);
    int a;
    a = amt;
    m_pay.delete();
    while (a >= 2) begin m_pay.push_back(2); a -= 2; end
    if (a == 1) m_pay.push_back(1);
  endtask

  task automatic model_step(input int price, input logic [2:0] c, input logic a, input logic k);
    int n, rem;
    n = int'(c[0]) + int'(c[1]) + int'(c[2]);
    rem = 0;
    foreach (m_pay[j]) rem += m_pay[j];
    m_rej = 0;
    if (m_disp_left > 0) begin
      m_rej = (n > 0);
      m_disp_left--;
      if (m_disp_left == 0) begin
        m_in_change = 1;
        fill_pay(m_shown);
        m_req_on = (m_pay.size() > 0);
      end
    end else if (m_in_change) begin
      m_rej = (n > 0);
      if (m_req_on) begin
        m_shown = rem;
        if (a) begin
          void'(m_pay.pop_front());
          m_req_on = 0;
        end
      end else if (rem == 0) begin
        m_in_change = 0;
        m_shown = 0;
        m_credit = 0;
      end else begin
        m_req_on = 1;
        m_shown = rem;
      end
    end else if (m_credit >= price) begin
      m_rej = (n > 0);
      m_shown = m_credit - price;
      m_disp_left = DISP;
      m_credit = 0;
    end else if (k && m_credit > 0) begin
      m_rej = (n > 0);
      m_in_change = 1;
      fill_pay(m_credit);
      m_req_on = (m_pay.size() > 0);
      m_credit = 0;
    end else if (n == 1) begin
      m_credit += (c[0] ? 1 : 0) + (c[1] ? 2 : 0) + (c[2] ? 5 : 0);
      m_shown = m_credit;
    end else if (n > 1) begin
      m_rej = 1;
    end
  endtask

  function automatic logic [8:0] model_out();
    logic f, s;
    f = m_in_change && m_req_on && (m_pay.size() > 0) && (m_pay[0] == 2);
    s = m_in_change && m_req_on && (m_pay.size() > 0) && (m_pay[0] == 1);
    return {4'(m_shown), (m_disp_left > 0), f, s, m_rej, (m_disp_left > 0) || m_in_change};
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [2:0] c;
    logic       a;
    logic [8:0] exp;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic [2:0] c, input logic a, input logic [8:0] e);
    vec_t v;
    v.c = c; v.a = a; v.exp = e;
    tv.push_back(v);
  endtask

  localparam logic [2:0] NO = 3'b000;
  localparam logic [2:0] SH = 3'b001;
  localparam logic [2:0] FL = 3'b010;
  localparam logic [2:0] CR = 3'b100;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int nd;
    bit sh_seen, got_fl, dis_seen;
    logic [2:0] rc;
    logic ra, rk;

    for (int i = 0; i < NDUT; i++) begin
      coins[i] = '0; ack[i] = 1'b0; cancel[i] = 1'b0;
    end
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NDUT; i++) check("reset_held", i, outv(i), '0);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NDUT; i++) check("reset_rel", i, outv(i), '0);

    // Exact payment with two florins, PRICE=4.
    add(NO, 0, ev(0,0,0,0,0,0));
    add(FL, 0, ev(2,0,0,0,0,0));
    add(NO, 0, ev(2,0,0,0,0,0));
    add(FL, 0, ev(4,0,0,0,0,0));
    add(NO, 0, ev(0,1,0,0,0,1));
    add(NO, 0, ev(0,1,0,0,0,1));
    add(NO, 0, ev(0,1,0,0,0,1));
    add(NO, 0, ev(0,0,0,0,0,1));
    add(NO, 0, ev(0,0,0,0,0,0));
    // Crown, one shilling change.
    add(CR, 0, ev(5,0,0,0,0,0));
    add(NO, 0, ev(1,1,0,0,0,1));
    add(NO, 0, ev(1,1,0,0,0,1));
    add(NO, 0, ev(1,1,0,0,0,1));
    add(NO, 0, ev(1,0,0,1,0,1));
    add(NO, 0, ev(1,0,0,1,0,1));
    add(NO, 1, ev(1,0,0,0,0,1));
    add(NO, 0, ev(0,0,0,0,0,0));
    // Double coin rejected (stray ack ignored), then crown during VEND.
    add(SH | FL, 1, ev(0,0,0,0,1,0));
    add(NO, 0, ev(0,0,0,0,0,0));
    add(FL, 0, ev(2,0,0,0,0,0));
    add(CR, 0, ev(7,0,0,0,0,0));
    add(NO, 0, ev(3,1,0,0,0,1));
    add(CR, 0, ev(3,1,0,0,1,1));
    add(NO, 0, ev(3,1,0,0,0,1));
    add(NO, 0, ev(3,0,1,0,0,1));
    add(NO, 1, ev(3,0,0,0,0,1));
    add(NO, 0, ev(1,0,0,1,0,1));
    add(NO, 1, ev(1,0,0,0,0,1));
    add(NO, 0, ev(0,0,0,0,0,0));

    for (int r = 0; r < tv.size(); r++) begin
      tick(0, tv[r].c, tv[r].a, 1'b0);
      check("vec", r, outv(0), tv[r].exp);
    end

    // PRICE=1, crown: change 4 paid as two florins.
    sh_seen = 0; nd = 0; got_fl = 0;
    tick(1, CR, 0, 0);
    check("p1_credit", 0, outv(1), ev(5,0,0,0,0,0));
    for (int w = 0; w < 12 && !got_fl; w++) begin
      tick(1, NO, 0, 0);
      sh_seen |= sh[1];
      if (disp[1]) nd++;
      got_fl = fl[1];
    end
    check_int("p1_florin_seen", int'(got_fl), 1);
    check_int("p1_disp_cycles", nd, DISP);
    check("p1_req1", 0, outv(1), ev(4,0,1,0,0,1));
    tick(1, NO, 0, 0);
    check("p1_hold", 0, outv(1), ev(4,0,1,0,0,1));
    tick(1, NO, 1, 0);
    check("p1_gap", 0, outv(1), ev(4,0,0,0,0,1));
    tick(1, NO, 0, 0);
    check("p1_req2", 0, outv(1), ev(2,0,1,0,0,1));
    tick(1, NO, 1, 0);
    sh_seen |= sh[1];
    check("p1_ack2", 0, outv(1), ev(2,0,0,0,0,1));
    tick(1, NO, 0, 0);
    sh_seen |= sh[1];
    check("p1_idle", 0, outv(1), ev(0,0,0,0,0,0));
    check_int("p1_no_shilling", int'(sh_seen), 0);

    // Asynchronous reset while a florin is requested.
    tick(0, FL, 0, 0);
    tick(0, CR, 0, 0);
    got_fl = 0;
    for (int w = 0; w < 12 && !got_fl; w++) begin
      tick(0, NO, 0, 0);
      got_fl = fl[0];
    end
    check_int("rst_florin_seen", int'(got_fl), 1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_async", 0, outv(0), '0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_after", 0, outv(0), '0);
    tick(0, FL, 0, 0);
    check("rst_resume", 0, outv(0), ev(2,0,0,0,0,0));
    do_reset();

`ifdef VEND_REFUND_EN
    // PRICE=10: crown then cancel, refund 2+2+1 without dispensing.
    begin
      logic [2:0]  c6 [8] = '{CR, NO, NO, NO, NO, NO, NO, NO};
      logic        a6 [8] = '{0, 0, 1, 0, 1, 0, 1, 0};
      logic        k6 [8] = '{0, 1, 0, 0, 0, 0, 0, 0};
      logic [8:0]  e6 [8];
      e6[0] = ev(5,0,0,0,0,0); e6[1] = ev(5,0,1,0,0,1);
      e6[2] = ev(5,0,0,0,0,1); e6[3] = ev(3,0,1,0,0,1);
      e6[4] = ev(3,0,0,0,0,1); e6[5] = ev(1,0,0,1,0,1);
      e6[6] = ev(1,0,0,0,0,1); e6[7] = ev(0,0,0,0,0,0);
      dis_seen = 0;
      for (int r = 0; r < 8; r++) begin
        tick(2, c6[r], a6[r], k6[r]);
        dis_seen |= disp[2];
        check("refund", r, outv(2), e6[r]);
      end
      check_int("refund_no_dispense", int'(dis_seen), 0);
    end
`endif

    // Randomised run against the reference model on every instance.
    for (int i = 0; i < NDUT; i++) begin
      do_reset();
      model_reset();
      for (int n = 0; n < 700; n++) begin
        rc[0] = ($urandom_range(0, 7) == 0);
        rc[1] = ($urandom_range(0, 7) == 0);
        rc[2] = ($urandom_range(0, 7) == 0);
        ra = ($urandom_range(0, 2) == 0);
`ifdef VEND_REFUND_EN
        rk = ($urandom_range(0, 15) == 0);
`else
        rk = 1'b0;
`endif
        tick(i, rc, ra, rk);
        model_step(price_of(i), rc, ra, rk);
        check("rand", i, outv(i), model_out());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
